// File: rtl/scie_pkg.sv
// Shared constants and funct3 encoding for the SCIE custom-3 datapath.
package scie_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] SCIE_OPCODE = 7'h7B;
    localparam logic [6:0] SCIE_FUNCT7 = 7'h00;

    typedef enum logic [2:0] {
        RELU = 3'd0,
        MAXS = 3'd1,
        MINS = 3'd2,
        MAXU = 3'd3,
        MINU = 3'd4,
        ABS  = 3'd5,
        ROL  = 3'd6,
        ROR  = 3'd7
    } scie_op_e;

endpackage

// File: rtl/scie_alu.sv
// SCIE operation unit: computes every funct3 operation from rs1/rs2.
// Latency: combinational. Backpressure: none, no handshake.
// Build gating of the extended ops is applied by the caller, not here.
module scie_alu
    import scie_pkg::*;
(
    input  scie_op_e          op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic [XLEN-1:0]   result
);

    logic [4:0]          rot_amt;
    logic [2*XLEN-1:0]   rol_wide;
    logic [2*XLEN-1:0]   ror_wide;
    logic                lt_signed;
    logic                lt_unsigned;

    // Rotates are a shift of the operand doubled up, so an amount of 0 falls out naturally.
    assign rot_amt     = rs2[4:0];
    assign rol_wide    = {rs1, rs1} << rot_amt;
    assign ror_wide    = {rs1, rs1} >> rot_amt;
    assign lt_signed   = $signed(rs1) < $signed(rs2);
    assign lt_unsigned = rs1 < rs2;

    always_comb begin
        result = '0;
        case (op)
            RELU:    result = rs1[XLEN-1] ? '0 : rs1;
            MAXS:    result = lt_signed ? rs2 : rs1;
            MINS:    result = lt_signed ? rs1 : rs2;
            MAXU:    result = lt_unsigned ? rs2 : rs1;
            MINU:    result = lt_unsigned ? rs1 : rs2;
            ABS:     result = rs1[XLEN-1] ? (~rs1 + 1'b1) : rs1;
            ROL:     result = rol_wide[2*XLEN-1:XLEN];
            ROR:     result = ror_wide[XLEN-1:0];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/scie_unpipelined.sv
// SCIE custom-3 execute slot: decode, valid check and ReLU (plus min/max/abs/rotate when SCIE_EXT_OPS_EN is defined).
// Latency: zero, io_rd is purely combinational in io_insn/io_rs1/io_rs2.
// Backpressure: none; clock and reset exist only for the port contract.
module scie_unpipelined
    import scie_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       io_insn,
    input  logic [XLEN-1:0]   io_rs1,
    input  logic [XLEN-1:0]   io_rs2,
    output logic [XLEN-1:0]   io_rd
);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             insn_valid;
    logic             op_enabled;
    logic [XLEN-1:0]  alu_result;
    logic             unused_ports;

    assign opcode = io_insn[6:0];
    assign funct3 = io_insn[14:12];
    assign funct7 = io_insn[31:25];

    // Register index fields and the clock/reset pins carry no meaning here.
    assign unused_ports = ^{clock, reset, io_insn[24:15], io_insn[11:7]};

    assign insn_valid = (opcode == SCIE_OPCODE) && (funct7 == SCIE_FUNCT7);

`ifdef SCIE_EXT_OPS_EN
    assign op_enabled = 1'b1;
`else
    assign op_enabled = (funct3 == RELU);
`endif

    scie_alu u_alu (
        .op     (scie_op_e'(funct3)),
        .rs1    (io_rs1),
        .rs2    (io_rs2),
        .result (alu_result)
    );

    assign io_rd = (insn_valid && op_enabled) ? alu_result : '0;

endmodule

// File: tb/tb_scie_unpipelined.sv
// Vector table plus short sequences for the SCIE datapath; expectations queued per stimulus.
module tb_scie_unpipelined;

`ifdef SCIE_EXT_OPS_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] io_insn;
    logic [31:0] io_rs1;
    logic [31:0] io_rs2;
    logic [31:0] io_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    scie_unpipelined #(.XLEN(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .io_insn (io_insn),
        .io_rs1  (io_rs1),
        .io_rs2  (io_rs2),
        .io_rd   (io_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input int f3);
        logic [31:0] w;
        w = 32'h0000_007B;
        w[14:12] = f3[2:0];
        return w;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] v);
        return EXT ? v : 32'h0;
    endfunction

    task automatic add(input string n, input logic [31:0] insn, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] exp);
        vec_t v;
        v.name = n; v.insn = insn; v.rs1 = rs1; v.rs2 = rs2; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input string n, input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] exp);
        io_insn = insn;
        io_rs1  = rs1;
        io_rs2  = rs2;
        exp_q.push_back(exp);
        name_q.push_back(n);
    endtask

    task automatic check_out();
        logic [31:0] e;
        string       n;
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h, required an expected entry", io_rd);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (io_rd !== e) begin
                errors++;
                $display("FAIL %s: io_rd=%h required %h", n, io_rd, e);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        io_insn = 32'h0;
        io_rs1  = 32'h0;
        io_rs2  = 32'h0;

        // Reset asserted with all-zero inputs: output is zero.
        @(negedge clock);
        drive("reset_state", 32'h0, 32'h0, 32'h0, 32'h0);
        check_out();
        // Output follows inputs while reset is held.
        drive("relu_in_reset", 32'h7B, 32'd5376, 32'h0, 32'd5376);
        check_out();
        @(negedge clock);
        reset = 1'b0;

        add("relu_pos_8192",  32'h7B, 32'd8192,  32'h1234_5678, 32'd8192);
        add("relu_pos_3328",  32'h7B, 32'd3328,  32'h1234_5678, 32'd3328);
        add("relu_pos_12800", 32'h7B, 32'd12800, 32'h1234_5678, 32'd12800);
        add("relu_zero",      32'h7B, 32'd0,     32'hFFFF_FFFF, 32'd0);
        add("relu_max_pos",   32'h7B, 32'h7FFF_FFFF, 32'h5, 32'h7FFF_FFFF);
        add("relu_neg_7936",  32'h7B, -32'sd7936,  32'h1234_5678, 32'h0);
        add("relu_neg_1024",  32'h7B, -32'sd1024,  32'h1234_5678, 32'h0);
        add("relu_neg_12288", 32'h7B, -32'sd12288, 32'h1234_5678, 32'h0);
        add("relu_min_neg",   32'h7B, 32'h8000_0000, 32'h1234_5678, 32'h0);
        add("relu_regfields", 32'h000F_8FFB, 32'd777, 32'h0, 32'd777);
        add("bad_opcode",     32'h0000_000B, 32'd4608, 32'h0, 32'h0);
        add("bad_funct7",     32'h0200_007B, 32'd4608, 32'h0, 32'h0);
        add("bad_funct7_top", 32'h8000_007B, 32'd4608, 32'h0, 32'h0);
        add("bad_f7_maxs",    32'h0200_107B, 32'd10, 32'd20, 32'h0);
        add("maxs",  mk(1), -32'sd5, 32'd3, ext(32'd3));
        add("mins",  mk(2), -32'sd5, 32'd3, ext(32'hFFFF_FFFB));
        add("maxu",  mk(3), -32'sd5, 32'd3, ext(32'hFFFF_FFFB));
        add("minu",  mk(4), -32'sd5, 32'd3, ext(32'd3));
        add("maxs_10_20", mk(1), 32'd10, 32'd20, ext(32'd20));
        add("mins_equal", mk(2), 32'd42, 32'd42, ext(32'd42));
        add("maxu_equal", mk(3), 32'hF000_0000, 32'hF000_0000, ext(32'hF000_0000));
        add("abs_neg256", mk(5), -32'sd256, 32'h0, ext(32'd256));
        add("abs_pos",    mk(5), 32'd99, 32'h0, ext(32'd99));
        add("abs_minint", mk(5), 32'h8000_0000, 32'h0, ext(32'h8000_0000));
        add("rol_1",      mk(6), 32'h8000_0001, 32'd1, ext(32'h0000_0003));
        add("ror_33",     mk(7), 32'h8000_0001, 32'd33, ext(32'hC000_0000));
        add("rol_0",      mk(6), 32'hDEAD_BEEF, 32'd0, ext(32'hDEAD_BEEF));
        add("ror_4",      mk(7), 32'h1234_5678, 32'd4, ext(32'h8123_4567));
        add("rol_31",     mk(6), 32'h0000_0003, 32'd31, ext(32'h8000_0001));

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].name, vecs[i].insn, vecs[i].rs1, vecs[i].rs2, vecs[i].exp);
            check_out();
        end

        // Mid-cycle input changes propagate without a clock edge.
        @(posedge clock);
        #2;
        drive("midcycle_a", 32'h7B, 32'd100, 32'h0, 32'd100);
        check_out();
        drive("midcycle_b", 32'h7B, 32'hFFFF_FF00, 32'h0, 32'h0);
        check_out();

        // Reset toggling does not disturb the output.
        @(negedge clock);
        drive("reset_rise", 32'h7B, 32'd5376, 32'd0, 32'd5376);
        reset = 1'b1;
        check_out();
        @(negedge clock);
        reset = 1'b0;
        drive("reset_fall", 32'h7B, 32'd5376, 32'd0, 32'd5376);
        check_out();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
